// File: rtl/stage5_ctrl_pkg.sv
// Shared encodings and the control-word bundle for the stage-5 controller.
// State codes, opcodes, select encodings and the stall strobe mask.
package stage5_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEMACC = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_PUSHI  = 4'h1;
    localparam logic [3:0] OP_PUSHUI = 4'h2;
    localparam logic [3:0] OP_ADD    = 4'h3;
    localparam logic [3:0] OP_SUB    = 4'h4;
    localparam logic [3:0] OP_AND    = 4'h5;
    localparam logic [3:0] OP_OR     = 4'h6;
    localparam logic [3:0] OP_LOAD   = 4'h7;
    localparam logic [3:0] OP_STORE  = 4'h8;
    localparam logic [3:0] OP_JMP    = 4'h9;
    localparam logic [3:0] OP_BZ     = 4'hA;
    localparam logic [3:0] OP_CALL   = 4'hB;
    localparam logic [3:0] OP_RET    = 4'hC;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [1:0] DST_PC   = 2'd0;
    localparam logic [1:0] DST_MSP  = 2'd1;
    localparam logic [1:0] DST_RSP  = 2'd2;
    localparam logic [1:0] DST_VALA = 2'd3;

    localparam logic [2:0] MD_VALA = 3'd0;
    localparam logic [2:0] MD_VALB = 3'd1;
    localparam logic [2:0] MD_SEXT = 3'd2;
    localparam logic [2:0] MD_ZEXT = 3'd3;
    localparam logic [2:0] MD_RES  = 3'd4;
    localparam logic [2:0] MD_PC   = 3'd5;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    typedef struct packed {
        logic       msp_write;
        logic       msp_pop;
        logic       rsp_write;
        logic       rsp_pop;
        logic       pc_write;
        logic       pc_source;
        logic       pc_add;
        logic       vala_write;
        logic       valb_write;
        logic       ir_write;
        logic       mem_read1;
        logic       mem_read2;
        logic       mem_write1;
        logic       mem_write2;
        logic [1:0] mem_dst1;
        logic [1:0] mem_dst2;
        logic [2:0] mem_data;
        logic [2:0] alu_op;
        logic       res_write;
        logic       halted;
    } ctrl_t;

    // Stall kills side effects only; selects and stack directions stay put.
    function automatic ctrl_t mask_strobes(ctrl_t c);
        ctrl_t m = c;
        m.msp_write  = 1'b0;
        m.rsp_write  = 1'b0;
        m.pc_write   = 1'b0;
        m.pc_add     = 1'b0;
        m.vala_write = 1'b0;
        m.valb_write = 1'b0;
        m.ir_write   = 1'b0;
        m.mem_read1  = 1'b0;
        m.mem_read2  = 1'b0;
        m.mem_write1 = 1'b0;
        m.mem_write2 = 1'b0;
        m.res_write  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/stage5_ctrl_decode.sv
// Combinational next-state and control-word table for the stage-5 FSM.
// Maps (state, opcode, ZeroFlag) to the word shown while in that state.
module stage5_ctrl_decode
    import stage5_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [2:0]     state_i,
    input  logic [OPW-1:0] op_i,
    input  logic           zero_i,
    output ctrl_t          cw_o,
    output logic [2:0]     next_o,
    output logic           illegal_o
);

    always_comb begin
        cw_o      = '0;
        next_o    = S_FETCH;
        illegal_o = 1'b0;
        unique case (state_i)
            S_FETCH: begin
                cw_o.pc_add     = 1'b1;
                cw_o.pc_write   = 1'b1;
                cw_o.mem_read1  = 1'b1;
                cw_o.mem_read2  = 1'b1;
                cw_o.ir_write   = 1'b1;
                cw_o.vala_write = 1'b1;
                cw_o.msp_write  = 1'b1;
                cw_o.msp_pop    = 1'b1;
                next_o          = S_DECODE;
            end
            S_DECODE: begin
                cw_o.valb_write = 1'b1;
                cw_o.mem_read2  = 1'b1;
                cw_o.mem_dst2   = DST_MSP;
                cw_o.msp_write  = 1'b1;
                cw_o.msp_pop    = 1'b1;
                unique case (op_i)
                    OP_NOP:              next_o = S_FETCH;
                    OP_PUSHI, OP_PUSHUI: next_o = S_WB;
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_JMP, OP_BZ, OP_CALL, OP_RET:
                        next_o = S_EXEC;
                    OP_LOAD, OP_STORE:   next_o = S_MEMACC;
                    OP_HALT:             next_o = S_HALT;
                    default: begin
                        illegal_o = 1'b1;
                        next_o    = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                next_o = S_WB;
                unique case (op_i)
                    OP_ADD: begin
                        cw_o.alu_op    = ALU_ADD;
                        cw_o.res_write = 1'b1;
                    end
                    OP_SUB: begin
                        cw_o.alu_op    = ALU_SUB;
                        cw_o.res_write = 1'b1;
                    end
                    OP_AND: begin
                        cw_o.alu_op    = ALU_AND;
                        cw_o.res_write = 1'b1;
                    end
                    OP_OR: begin
                        cw_o.alu_op    = ALU_OR;
                        cw_o.res_write = 1'b1;
                    end
                    OP_JMP: begin
                        cw_o.alu_op    = ALU_PASS;
                        cw_o.res_write = 1'b1;
                    end
                    OP_BZ: begin
                        cw_o.alu_op    = ALU_PASS;
                        cw_o.res_write = 1'b1;
                        next_o         = zero_i ? S_WB : S_FETCH;
                    end
                    OP_CALL: begin
                        cw_o.mem_write1 = 1'b1;
                        cw_o.mem_dst1   = DST_RSP;
                        cw_o.mem_data   = MD_PC;
                        cw_o.rsp_write  = 1'b1;
                    end
                    OP_RET: begin
                        cw_o.mem_read1  = 1'b1;
                        cw_o.mem_dst1   = DST_RSP;
                        cw_o.vala_write = 1'b1;
                        cw_o.rsp_write  = 1'b1;
                        cw_o.rsp_pop    = 1'b1;
                    end
                    default: next_o = S_FETCH;
                endcase
            end
            S_MEMACC: begin
                next_o = S_FETCH;
                unique case (op_i)
                    OP_LOAD: begin
                        cw_o.mem_read1  = 1'b1;
                        cw_o.mem_dst1   = DST_VALA;
                        cw_o.valb_write = 1'b1;
                        next_o          = S_WB;
                    end
                    OP_STORE: begin
                        cw_o.mem_write2 = 1'b1;
                        cw_o.mem_dst2   = DST_VALA;
                        cw_o.mem_data   = MD_VALB;
                    end
                    default: next_o = S_FETCH;
                endcase
            end
            S_WB: begin
                next_o = S_FETCH;
                unique case (op_i)
                    OP_PUSHI, OP_PUSHUI, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_LOAD: begin
                        cw_o.mem_write1 = 1'b1;
                        cw_o.mem_dst1   = DST_MSP;
                        cw_o.msp_write  = 1'b1;
                        cw_o.msp_pop    = 1'b0;
                        unique case (op_i)
                            OP_PUSHI:  cw_o.mem_data = MD_SEXT;
                            OP_PUSHUI: cw_o.mem_data = MD_ZEXT;
                            OP_LOAD:   cw_o.mem_data = MD_VALB;
                            default:   cw_o.mem_data = MD_RES;
                        endcase
                    end
                    OP_JMP, OP_BZ, OP_CALL, OP_RET: begin
                        cw_o.pc_write  = 1'b1;
                        cw_o.pc_source = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                cw_o.halted = 1'b1;
                next_o      = S_HALT;
            end
            default: next_o = S_FETCH;
        endcase
    end

endmodule

// File: rtl/stage5_control_unit.sv
// Stage-5 multi-cycle controller: state, opcode latch, retire counter,
// sticky Illegal and registered control word with stall strobe masking.
module stage5_control_unit
    import stage5_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [15:0]     IROut,
    input  logic            ZeroFlag,
    input  logic            Stall,
    output logic            MSPWrite,
    output logic            MSPPop,
    output logic            RSPWrite,
    output logic            RSPPop,
    output logic            PCWrite,
    output logic            PCSource,
    output logic            PCAdd,
    output logic            ValAWrite,
    output logic            ValBWrite,
    output logic            IRWrite,
    output logic            MemRead1,
    output logic            MemRead2,
    output logic            MemWrite1,
    output logic            MemWrite2,
    output logic [1:0]      MemDst1,
    output logic [1:0]      MemDst2,
    output logic [2:0]      MemData,
    output logic [2:0]      ALUOp,
    output logic            ResWrite,
    output logic            Halted,
    output logic            Illegal,
    output logic [CNTW-1:0] InstrCount
);

    // state_q is the state being entered; disp_q is the one on the outputs.
    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic [2:0]      disp_q;
    logic [OPW-1:0]  op_q;
    logic [OPW-1:0]  op_cur;
    ctrl_t           ctrl_q;
    ctrl_t           ctrl_d;
    ctrl_t           ctrl_out;
    logic            ill_q;
    logic            ill_set;
    logic [CNTW-1:0] cnt_q;
    logic            hold;
    logic            retire;
    logic            unused_ir;

    assign unused_ir = ^IROut[15-OPW:0];
    assign op_cur    = (state_q == S_DECODE) ? IROut[15 -: OPW] : op_q;
    assign hold      = Stall && (disp_q != S_HALT);
    assign retire    = (state_q == S_FETCH) && (disp_q != S_FETCH);

    stage5_ctrl_decode #(
        .OPW (OPW)
    ) u_decode (
        .state_i   (state_q),
        .op_i      (op_cur),
        .zero_i    (ZeroFlag),
        .cw_o      (ctrl_d),
        .next_o    (state_d),
        .illegal_o (ill_set)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
            disp_q  <= S_FETCH;
            op_q    <= '0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (!hold) begin
            state_q <= state_d;
            disp_q  <= state_q;
            ctrl_q  <= ctrl_d;
            if (state_q == S_DECODE) op_q <= op_cur;
            if (ill_set) ill_q <= 1'b1;
            if (retire) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ctrl_out = Stall ? mask_strobes(ctrl_q) : ctrl_q;

    assign MSPWrite   = ctrl_out.msp_write;
    assign MSPPop     = ctrl_out.msp_pop;
    assign RSPWrite   = ctrl_out.rsp_write;
    assign RSPPop     = ctrl_out.rsp_pop;
    assign PCWrite    = ctrl_out.pc_write;
    assign PCSource   = ctrl_out.pc_source;
    assign PCAdd      = ctrl_out.pc_add;
    assign ValAWrite  = ctrl_out.vala_write;
    assign ValBWrite  = ctrl_out.valb_write;
    assign IRWrite    = ctrl_out.ir_write;
    assign MemRead1   = ctrl_out.mem_read1;
    assign MemRead2   = ctrl_out.mem_read2;
    assign MemWrite1  = ctrl_out.mem_write1;
    assign MemWrite2  = ctrl_out.mem_write2;
    assign MemDst1    = ctrl_out.mem_dst1;
    assign MemDst2    = ctrl_out.mem_dst2;
    assign MemData    = ctrl_out.mem_data;
    assign ALUOp      = ctrl_out.alu_op;
    assign ResWrite   = ctrl_out.res_write;
    assign Halted     = ctrl_out.halted;
    assign Illegal    = ill_q;
    assign InstrCount = cnt_q;

endmodule
